// File: rtl/alu_pkg.sv
// Opcode constants and legality check shared by the ALU and its execute-stage driver.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'h7;

  // Legal opcodes occupy the contiguous range ADD..SLL.
  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
    return (op <= ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_exec_stage_reg.sv
// Generic valid/ready pipeline register with synchronous flush; full-throughput
// because the slot is refillable in the same cycle it drains.
module alu_exec_stage_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         upValid,
  output logic         upReady_c,
  input  logic [W-1:0] upData,
  output logic         valid,
  output logic [W-1:0] data,
  input  logic         downReady
);

  assign upReady_c = !valid || downReady;

  // Flush clears occupancy only; payload is left as-is since valid gates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (upReady_c) begin
      valid <= upValid;
      if (upValid) begin
        data <= upData;
      end
    end
  end

endmodule

// File: rtl/alu_exec_driver.sv
// Execute-stage initiator: registers operands onto the external ALU (S1) and
// captures its result into the EX/MEM register (S2) with backpressure and flush.
module alu_exec_driver
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEST_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [WIDTH-1:0]  inA,
  input  logic [WIDTH-1:0]  inB,
  input  logic [3:0]        inOp,
  input  logic [DEST_W-1:0] inDest,
  output logic [WIDTH-1:0]  aluInputA,
  output logic [WIDTH-1:0]  aluInputB,
  output logic [31:0]       aluOpCode,
  input  logic [WIDTH-1:0]  aluOut,
  output logic              outValid,
  input  logic              outReady,
  output logic [WIDTH-1:0]  outResult,
  output logic [DEST_W-1:0] outDest,
  output logic              outZero,
  output logic              outIllegal,
  output logic [CNT_W-1:0]  opCount
);

  localparam int unsigned ALU_OPCODE_W = 32;
  localparam int unsigned S1_W = 2 * WIDTH + ALU_OP_W + DEST_W;
  localparam int unsigned S2_W = WIDTH + DEST_W + 2;

  logic              s1Valid;
  logic              s2Valid;
  logic              s2Ready;
  logic [S1_W-1:0]   s1Data;
  logic [S2_W-1:0]   s2Data;
  logic [ALU_OP_W-1:0] s1Op;
  logic [DEST_W-1:0] s1Dest;
  logic              s1Illegal;
  logic              s1Zero;
  logic [WIDTH-1:0]  s1Result;

  alu_exec_stage_reg #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .upValid   (inValid),
    .upReady_c (inReady),
    .upData    ({inA, inB, inOp, inDest}),
    .valid     (s1Valid),
    .data      (s1Data),
    .downReady (s2Ready)
  );

  assign {aluInputA, aluInputB, s1Op, s1Dest} = s1Data;
  assign aluOpCode = ALU_OPCODE_W'(s1Op);

  // Illegal opcodes still retire, with the ALU output discarded.
  always_comb begin
    s1Illegal = !alu_op_legal(s1Op);
    s1Result  = s1Illegal ? '0 : aluOut;
    s1Zero    = (s1Result == '0);
  end

  alu_exec_stage_reg #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .upValid   (s1Valid),
    .upReady_c (s2Ready),
    .upData    ({s1Result, s1Dest, s1Zero, s1Illegal}),
    .valid     (s2Valid),
    .data      (s2Data),
    .downReady (outReady)
  );

  assign {outResult, outDest, outZero, outIllegal} = s2Data;
  assign outValid = s2Valid;

  // Retired-operation counter; a handshake coinciding with flush is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opCount <= '0;
    end else if (!flush && s2Valid && outReady) begin
      opCount <= opCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_exec_driver.sv
// Randomized and directed bench for alu_exec_driver against a transaction-queue model.
module tb_alu_exec_driver;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic [31:0] inA = '0;
  logic [31:0] inB = '0;
  logic [3:0]  inOp = '0;
  logic [4:0]  inDest = '0;

  logic        inReady, outValid, outZero, outIllegal;
  logic [31:0] aluInputA, aluInputB, aluOpCode, aluOut, outResult;
  logic [4:0]  outDest;
  logic [15:0] opCount;

  logic        sInReady, sOutValid, sOutZero, sOutIllegal;
  logic [31:0] sAluA, sAluB, sAluOp, sAluOut, sOutResult;
  logic [4:0]  sOutDest;
  logic [3:0]  sOpCount;

  always #5 clk = ~clk;

  function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] op);
    case (op)
      32'd0:   return a + b;
      32'd1:   return a - b;
      32'd2:   return a & b;
      32'd3:   return a | b;
      32'd4:   return a ^ b;
      32'd5:   return ~(a | b);
      32'd6:   return 32'($signed(a) < $signed(b));
      32'd7:   return a << b[4:0];
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign aluOut  = refAlu(aluInputA, aluInputB, aluOpCode);
  assign sAluOut = refAlu(sAluA, sAluB, sAluOp);

  alu_exec_driver #(.WIDTH(32), .DEST_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .inValid(inValid), .inReady(inReady),
    .inA(inA), .inB(inB), .inOp(inOp), .inDest(inDest),
    .aluInputA(aluInputA), .aluInputB(aluInputB), .aluOpCode(aluOpCode), .aluOut(aluOut),
    .outValid(outValid), .outReady(outReady), .outResult(outResult), .outDest(outDest),
    .outZero(outZero), .outIllegal(outIllegal), .opCount(opCount)
  );

  // Narrow-counter instance so counter wrap is exercised within a short run.
  alu_exec_driver #(.WIDTH(32), .DEST_W(5), .CNT_W(4)) dutSmall (
    .clk(clk), .rst_n(rst_n), .flush(flush), .inValid(inValid), .inReady(sInReady),
    .inA(inA), .inB(inB), .inOp(inOp), .inDest(inDest),
    .aluInputA(sAluA), .aluInputB(sAluB), .aluOpCode(sAluOp), .aluOut(sAluOut),
    .outValid(sOutValid), .outReady(outReady), .outResult(sOutResult), .outDest(sOutDest),
    .outZero(sOutZero), .outIllegal(sOutIllegal), .opCount(sOpCount)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  dest;
    logic [31:0] res;
    logic        ill;
    int          age;
  } ent_t;

  ent_t        q[$];
  int unsigned cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Entry ages count edges since acceptance; the head is visible once it has aged.
  task automatic compareAndAdvance();
    logic expOv, expIr;
    int   s1i;
    ent_t e;
    expOv = (q.size() > 0) && (q[0].age >= 1);
    expIr = (q.size() < 2) || outReady;
    chk("outValid", 32'(outValid), 32'(expOv));
    chk("inReady", 32'(inReady), 32'(expIr));
    chk("sOutValid", 32'(sOutValid), 32'(expOv));
    chk("sInReady", 32'(sInReady), 32'(expIr));
    chk("opCount", 32'(opCount), cnt & 32'hFFFF);
    chk("sOpCount", 32'(sOpCount), cnt & 32'hF);
    if (expOv) begin
      chk("outResult", outResult, q[0].res);
      chk("outDest", 32'(outDest), 32'(q[0].dest));
      chk("outZero", 32'(outZero), 32'(q[0].res == 0));
      chk("outIllegal", 32'(outIllegal), 32'(q[0].ill));
      chk("sOutResult", sOutResult, q[0].res);
      chk("sOutDest", 32'(sOutDest), 32'(q[0].dest));
      chk("sOutFlags", 32'({sOutZero, sOutIllegal}), 32'({q[0].res == 0, q[0].ill}));
    end
    s1i = expOv ? 1 : 0;
    if (q.size() > s1i) begin
      chk("aluInputA", aluInputA, q[s1i].a);
      chk("aluInputB", aluInputB, q[s1i].b);
      chk("aluOpCode", aluOpCode, 32'(q[s1i].op));
      chk("sAluOp", sAluOp, 32'(q[s1i].op));
    end
    if (rst_n) begin
      if (flush) begin
        q.delete();
      end else begin
        if (expOv && outReady) begin
          cnt++;
          void'(q.pop_front());
        end
        foreach (q[i]) q[i].age++;
        if (inValid && expIr) begin
          e.a = inA; e.b = inB; e.op = inOp; e.dest = inDest;
          e.ill = (inOp > 4'd7);
          e.res = e.ill ? 32'd0 : refAlu(inA, inB, 32'(inOp));
          e.age = 0;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [4:0] d,
                      input logic ordy, input logic fl);
    @(negedge clk);
    inValid = iv; inA = a; inB = b; inOp = op; inDest = d; outReady = ordy; flush = fl;
    #1;
    compareAndAdvance();
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic randomSteps(input int n);
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom());
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom());
      step($urandom_range(0, 3) != 0, a, b, op, 5'($urandom_range(0, 31)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
  endtask

  logic [31:0] streamExp [7];

  initial begin
    streamExp = '{32'd3, 32'hFFFFFFFF, 32'd0, 32'd3, 32'd3, 32'hFFFFFFFC, 32'd1};

    repeat (3) @(negedge clk);
    #1;
    chk("rstOutValid", 32'(outValid), 32'd0);
    chk("rstInReady", 32'(inReady), 32'd1);
    chk("rstAluOpCode", aluOpCode, 32'd0);
    chk("rstAluInputA", aluInputA, 32'd0);
    chk("rstAluInputB", aluInputB, 32'd0);
    chk("rstOutResult", outResult, 32'd0);
    chk("rstOutDest", 32'(outDest), 32'd0);
    chk("rstFlags", 32'({outZero, outIllegal}), 32'd0);
    chk("rstOpCount", 32'(opCount), 32'd0);
    rst_n = 1'b1;

    // Single ADD: visible two cycles after acceptance.
    step(1'b1, 32'd1, 32'd2, ALU_ADD, 5'd3, 1'b1, 1'b0);
    idle();
    chk("addEarly", 32'(outValid), 32'd0);
    idle();
    chk("addValid", 32'(outValid), 32'd1);
    chk("addResult", outResult, 32'd3);
    chk("addDest", 32'(outDest), 32'd3);
    chk("addZero", 32'(outZero), 32'd0);
    idle();
    chk("addCount", 32'(opCount), 32'd1);

    // Back-to-back stream of the first seven opcodes.
    for (int k = 0; k < 9; k++) begin
      if (k < 7) step(1'b1, 32'd1, 32'd2, 4'(k), 5'(k), 1'b1, 1'b0);
      else idle();
      if (k >= 2) chk("streamResult", outResult, streamExp[k-2]);
    end
    idle();
    chk("streamCount", 32'(opCount), 32'd8);

    // Five-cycle stall with three offers.
    step(1'b1, 32'd10, 32'd20, ALU_ADD, 5'd1, 1'b0, 1'b0);
    step(1'b1, 32'd50, 32'd8, ALU_SUB, 5'd2, 1'b0, 1'b0);
    step(1'b1, 32'hF0, 32'hFF, ALU_XOR, 5'd3, 1'b0, 1'b0);
    chk("stallInReady", 32'(inReady), 32'd0);
    step(1'b1, 32'hF0, 32'hFF, ALU_XOR, 5'd3, 1'b0, 1'b0);
    step(1'b1, 32'hF0, 32'hFF, ALU_XOR, 5'd3, 1'b0, 1'b0);
    chk("stallHeld", outResult, 32'd30);
    chk("stallS1", aluInputA, 32'd50);
    step(1'b1, 32'hF0, 32'hFF, ALU_XOR, 5'd3, 1'b1, 1'b0);
    chk("releaseInReady", 32'(inReady), 32'd1);
    chk("release0", outResult, 32'd30);
    idle();
    chk("release1", outResult, 32'd42);
    idle();
    chk("release2", outResult, 32'h0F);
    idle();

    // Illegal opcode retires with a forced zero result.
    step(1'b1, 32'd5, 32'd5, 4'b1010, 5'd7, 1'b1, 1'b0);
    idle();
    idle();
    chk("illValid", 32'(outValid), 32'd1);
    chk("illFlag", 32'(outIllegal), 32'd1);
    chk("illResult", outResult, 32'd0);
    chk("illZero", 32'(outZero), 32'd1);
    idle();
    chk("illCount", 32'(opCount), 32'd12);

    // Flush with both stages full, an offer and an output handshake pending.
    step(1'b1, 32'd3, 32'd4, ALU_ADD, 5'd1, 1'b0, 1'b0);
    step(1'b1, 32'd6, 32'd7, ALU_OR, 5'd2, 1'b0, 1'b0);
    step(1'b1, 32'd9, 32'd9, ALU_AND, 5'd4, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("flushValid", 32'(outValid), 32'd0);
      chk("flushInReady", 32'(inReady), 32'd1);
      chk("flushCount", 32'(opCount), 32'd12);
    end

    randomSteps(4000);

    // Asynchronous reset mid-stream.
    step(1'b1, 32'd1, 32'd1, ALU_ADD, 5'd0, 1'b1, 1'b0);
    step(1'b1, 32'd2, 32'd2, ALU_ADD, 5'd1, 1'b1, 1'b0);
    step(1'b1, 32'd3, 32'd3, ALU_ADD, 5'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("asyncOutValid", 32'(outValid), 32'd0);
    chk("asyncOpCount", 32'(opCount), 32'd0);
    chk("asyncSOpCount", 32'(sOpCount), 32'd0);
    chk("asyncInReady", 32'(inReady), 32'd1);
    q.delete();
    cnt = 0;
    step(1'b0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    randomSteps(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec_driver.md
# alu_exec_driver

Execute-stage initiator that feeds the existing combinational ALU and captures its result. It accepts decoded operations from the ID stage over a valid/ready handshake, registers operands and opcode onto the ALU's `inputA`/`inputB`/`aluOpCode` ports, and latches `out` into an EX/MEM result register with backpressure. Two register stages; throughput one operation per cycle; synchronous flush for branch/exception squash.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; matches the ALU `[32:1]` ports.
- `DEST_W`, 5, destination register tag width.
- `CNT_W`, 16, retired-operation counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `flush`  in  1  synchronous squash of all in-flight operations.
- `inValid`  in  1  ID stage presents an operation.
- `inReady`  out  1  driver accepts this cycle.
- `inA`, `inB`  in  WIDTH  operands.
- `inOp`  in  4  ALU opcode.
- `inDest`  in  DEST_W  destination tag, passed through.
- `aluInputA`, `aluInputB`  out  WIDTH  to ALU `inputA`/`inputB`.
- `aluOpCode`  out  32  to ALU `aluOpCode`; bits above [4:1] are always 0.
- `aluOut`  in  WIDTH  from ALU `out`.
- `outValid`  out  1  result available to MEM stage.
- `outReady`  in  1  MEM stage accepts.
- `outResult`  out  WIDTH  captured ALU result.
- `outDest`  out  DEST_W  tag of the result.
- `outZero`  out  1  `outResult == 0`.
- `outIllegal`  out  1  opcode outside the legal set.
- `opCount`  out  CNT_W  count of completed output handshakes.

## Operation
- Legal opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT (signed), 0111 SLL (shift by `inB[5:1]`). 1000–1111 are illegal.
- Stage S1 (operand register): `s1Valid`, A, B, op, dest. Its A, B and op drive the ALU ports directly.
- Stage S2 (result register): `s2Valid`, result, dest, zero, illegal.
- `s2Advance = s1Valid && (!s2Valid || outReady)`.
- `inReady = !s1Valid || s2Advance`. This is combinational from `outReady`; no other comb path in→out.
- An S1 load requires `inValid && inReady`.
- An illegal opcode still flows: S2 result is forced to 0, `outIllegal`=1 and `outZero`=1. The ALU output is ignored for that operation.
- `opCount` increments on `outValid && outReady` and wraps from 0xFFFF to 0x0000. Flush and reset are its only non-increment effects: flush leaves it unchanged; reset clears it.
- `flush` takes priority over all events. At the edge it clears `s1Valid` and `s2Valid`. Any input offered in the same cycle is dropped even if `inReady`=1. An output handshake in the same cycle does not count.
- Reset values: all valids 0; `aluInputA`/`aluInputB`/`aluOpCode`, `outResult`, `outDest` are 0; `outZero`=0; `outIllegal`=0; `opCount`=0; `inReady`=1 after reset.
- Reset asserted mid-operation discards everything immediately and asynchronously.

## Timing
- Operation accepted at edge N is driven on the ALU during cycle N+1. It is captured at edge N+1, so `outValid`=1 from cycle N+2. Latency is 2 cycles.
- Back-to-back accepts with `outReady`=1 give one result per cycle, in order.
- While `outValid && !outReady`, all S2 outputs are held stable.
- S1 also holds, so the ALU inputs are stable. `inReady` falls once S1 is full.
- When both stages are full and `outReady` rises, S2 and S1 advance on the same edge. `inReady` is 1 in that same cycle, so no bubble is inserted.
- A flush coinciding with a stall clears the stall, and `inReady`=1 the next cycle.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants `ALU_ADD` … `ALU_SLL`;
  - `ALU_OP_W`=4;
  - function `alu_op_legal(op)`.
- The ALU reuses the same package constants.
- Sub-module `alu_exec_stage_reg` is a generic valid/ready pipeline register with flush, instantiated for S1 and S2.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Reset, then inA=1, inB=2, inOp=ADD, dest=3, outReady=1 → cycle N+2: outValid=1, outResult=3, outDest=3, outZero=0, opCount=1.
- Stream ADD, SUB, AND, OR, XOR, NOR, SLT with A=1, B=2, one per cycle → results 3, 0xFFFFFFFF, 0, 3, 3, 0xFFFFFFFC, 1 on consecutive cycles. opCount=7.
- Hold outReady=0 for 5 cycles with 3 ops offered → the first result is held stable and the second sits in S1. inReady=0 from the third offer. Release → the three results appear on three consecutive cycles, in order.
- inOp=1010 with A=5, B=5 → outIllegal=1, outResult=0, outZero=1, and the operation still counts in opCount.
- With both stages full, assert flush while inValid=1 and outReady=1 → next cycle outValid=0, opCount unchanged, the offered op never appears, inReady=1.
- Preload opCount to 0xFFFF via 65535 handshakes (or force), complete one more → opCount=0. Assert rst_n=0 mid-stream → outValid=0 and opCount=0 immediately, without waiting for a clock edge.
